// File: rtl/key_fre_ctrl_if.sv
// Key pins in, selection index out, for the debounced key controller.
// idx_valid is a pulse-only strobe with no ready: it is high for exactly the one cycle in which idx takes its new value, and the consumer must take it then.
interface key_fre_ctrl_if;
    logic       key_up;
    logic       key_dn;
    logic [3:0] idx;
    logic       idx_valid;
    logic       key_busy;
    logic [2:0] dbg_state;

    modport slave (
        input  key_up,
        input  key_dn,
        output idx,
        output idx_valid,
        output key_busy,
        output dbg_state
    );

    modport master (
        output key_up,
        output key_dn,
        input  idx,
        input  idx_valid,
        input  key_busy,
        input  dbg_state
    );
endinterface

// File: rtl/key_fre_ctrl.sv
// Two-key debounce/arbitration FSM stepping a wrap-around index.
// Holding a key auto-repeats the step.
module key_fre_ctrl #(
    parameter int DEB_CYC  = 1_000_000,
    parameter int LONG_CYC = 50_000_000,
    parameter int REP_CYC  = 10_000_000,
    parameter int IDX_MAX  = 15
) (
    input  logic            clk,
    input  logic            rst,
    key_fre_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HOLD      = 3'd2,
        REPEAT    = 3'd3,
        DEB_REL   = 3'd4
    } state_e;

    typedef enum logic {SEL_UP = 1'b0, SEL_DN = 1'b1} sel_e;

    localparam logic [31:0] DEB_LAST  = 32'(DEB_CYC - 1);
    localparam logic [31:0] LONG_LAST = 32'(LONG_CYC - 1);
    localparam logic [31:0] REP_LAST  = 32'(REP_CYC - 1);
    localparam logic [3:0]  IDX_TOP   = 4'(IDX_MAX);

    logic        up_meta_q, up_s_q, dn_meta_q, dn_s_q;
    state_e      state_q, state_d;
    sel_e        sel_q, sel_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        step;
    logic        key_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_meta_q <= 1'b1;
            up_s_q    <= 1'b1;
            dn_meta_q <= 1'b1;
            dn_s_q    <= 1'b1;
            state_q   <= IDLE;
            sel_q     <= SEL_UP;
            cnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            up_meta_q <= bus.key_up;
            up_s_q    <= up_meta_q;
            dn_meta_q <= bus.key_dn;
            dn_s_q    <= dn_meta_q;
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Outside IDLE only the latched key matters; the other one is ignored.
    assign key_s = (sel_q == SEL_UP) ? up_s_q : dn_s_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!up_s_q) begin
                    sel_d   = SEL_UP;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end else if (!dn_s_q) begin
                    sel_d   = SEL_DN;
                    cnt_d   = '0;
                    state_d = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (key_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HOLD: begin
                if (key_s) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end else if (cnt_q == LONG_LAST) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            REPEAT: begin
                if (key_s) begin
                    cnt_d   = '0;
                    state_d = DEB_REL;
                end else if (cnt_q == REP_LAST) begin
                    step  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DEB_REL: begin
                if (!key_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (step) begin
            if (sel_q == SEL_UP) idx_d = (idx_q == IDX_TOP) ? 4'd0 : idx_q + 4'd1;
            else                 idx_d = (idx_q == 4'd0) ? IDX_TOP : idx_q - 4'd1;
        end
        valid_d = step;
        busy_d  = (state_d != IDLE);
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = valid_q;
    assign bus.key_busy  = busy_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_key_fre_ctrl.sv
// Directed bench for key_fre_ctrl with small timing constants.
// Expected indices and pulse times are worked out by hand from the key timing.
module tb_key_fre_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   pulses;
    logic [3:0] exp_q[$];
    logic [3:0] model_idx;

    key_fre_ctrl_if ifc();

    key_fre_ctrl #(
        .DEB_CYC (4),
        .LONG_CYC(20),
        .REP_CYC (5),
        .IDX_MAX (9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.idx_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        ifc.key_up = 1'b1;
        ifc.key_dn = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!done && ifc.key_busy === 1'b0) done = 1'b1;
            if (!done) tick(1);
        end
        chk("idle_wait", {31'd0, ifc.key_busy}, 32'd0);
    endtask

    task automatic press(input bit up, input int hold);
        if (up) ifc.key_up = 1'b0;
        else    ifc.key_dn = 1'b0;
        tick(hold);
        ifc.key_up = 1'b1;
        ifc.key_dn = 1'b1;
        tick(1);
        wait_idle();
    endtask

    initial begin
        int p0;
        n_cmp = 0;
        n_bad = 0;
        pulses = 0;
        rst = 1'b1;
        ifc.key_up = 1'b1;
        ifc.key_dn = 1'b1;
        tick(2);
        chk("rst_idx",   {28'd0, ifc.idx}, 32'd0);
        chk("rst_valid", {31'd0, ifc.idx_valid}, 32'd0);
        chk("rst_busy",  {31'd0, ifc.key_busy}, 32'd0);
        chk("rst_state", {29'd0, ifc.dbg_state}, 32'd0);
        rst = 1'b0;

        // Clean up press: step at edge 7, release after edge 10, IDLE at edge 17.
        p0 = pulses;
        ifc.key_up = 1'b0;
        tick(3);
        chk("c_busy_on", {31'd0, ifc.key_busy}, 32'd1);
        tick(3);
        chk("c_idx_pre", {28'd0, ifc.idx}, 32'd0);
        tick(1);
        chk("c_idx_step", {28'd0, ifc.idx}, 32'd1);
        chk("c_valid", {31'd0, ifc.idx_valid}, 32'd1);
        tick(3);
        ifc.key_up = 1'b1;
        tick(6);
        chk("c_busy_hold", {31'd0, ifc.key_busy}, 32'd1);
        tick(1);
        chk("c_busy_drop", {31'd0, ifc.key_busy}, 32'd0);
        tick(2);
        chk("c_pulses", 32'(pulses - p0), 32'd1);

        // Bounce: never low long enough to finish the press window.
        p0 = pulses;
        repeat (3) begin
            ifc.key_up = 1'b0;
            tick(2);
            ifc.key_up = 1'b1;
            tick(2);
        end
        tick(10);
        chk("b_pulses", 32'(pulses - p0), 32'd0);
        chk("b_idx",    {28'd0, ifc.idx}, 32'd1);
        chk("b_busy",   {31'd0, ifc.key_busy}, 32'd0);

        // Wrap-around from reset: one down press then eleven up presses.
        reset_dut();
        p0 = pulses;
        press(1'b0, 10);
        chk("w_dn_wrap", {28'd0, ifc.idx}, 32'd9);
        model_idx = 4'd9;
        for (int i = 0; i < 11; i++) begin
            model_idx = (model_idx == 4'd9) ? 4'd0 : model_idx + 4'd1;
            exp_q.push_back(model_idx);
            press(1'b1, 10);
            chk($sformatf("w_up%0d", i), {28'd0, ifc.idx}, {28'd0, exp_q.pop_front()});
        end
        chk("w_pulses", 32'(pulses - p0), 32'd12);

        // Auto-repeat: steps at edges 7, 27, 32, 37, 42, 47.
        reset_dut();
        p0 = pulses;
        ifc.key_up = 1'b0;
        tick(7);
        chk("r_first", {28'd0, ifc.idx}, 32'd1);
        tick(19);
        chk("r_pre_rep", {28'd0, ifc.idx}, 32'd1);
        tick(1);
        chk("r_rep1", {28'd0, ifc.idx}, 32'd2);
        chk("r_rep1_v", {31'd0, ifc.idx_valid}, 32'd1);
        tick(20);
        chk("r_last", {28'd0, ifc.idx}, 32'd6);
        ifc.key_up = 1'b1;
        tick(1);
        wait_idle();
        chk("r_pulses", 32'(pulses - p0), 32'd6);
        chk("r_final", {28'd0, ifc.idx}, 32'd6);

        // Simultaneous fall: up wins, down activity during the up press is ignored.
        reset_dut();
        p0 = pulses;
        ifc.key_up = 1'b0;
        ifc.key_dn = 1'b0;
        tick(3);
        ifc.key_dn = 1'b1;
        tick(7);
        ifc.key_dn = 1'b0;
        tick(2);
        ifc.key_up = 1'b1;
        tick(1);
        ifc.key_dn = 1'b1;
        tick(1);
        wait_idle();
        chk("s_up_wins", {28'd0, ifc.idx}, 32'd1);
        press(1'b0, 10);
        chk("s_dn_alone", {28'd0, ifc.idx}, 32'd0);
        chk("s_pulses", 32'(pulses - p0), 32'd2);

        // Reset inside REPEAT with idx 5, key kept held across reset.
        reset_dut();
        ifc.key_up = 1'b0;
        tick(42);
        chk("x_idx5", {28'd0, ifc.idx}, 32'd5);
        tick(2);
        chk("x_state", {29'd0, ifc.dbg_state}, 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("x_idx0",  {28'd0, ifc.idx}, 32'd0);
        chk("x_busy0", {31'd0, ifc.key_busy}, 32'd0);
        chk("x_valid0", {31'd0, ifc.idx_valid}, 32'd0);
        chk("x_state0", {29'd0, ifc.dbg_state}, 32'd0);
        p0 = pulses;
        tick(6);
        chk("x_pre", {28'd0, ifc.idx}, 32'd0);
        tick(1);
        chk("x_redeb", {28'd0, ifc.idx}, 32'd1);
        ifc.key_up = 1'b1;
        tick(1);
        wait_idle();
        chk("x_pulses", 32'(pulses - p0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
